cpu_dcache_write_buffer: RTL
============================

// Module: cpu_dcache_write_buffer
// PURPOSE
//  Posted-write buffer between the D-cache bus port and the system bus; the cache
//  drives it as if it were the bus. Writes are acknowledged once queued and drained
//  to the bus in order. Reads are ordered behind queued writes, with optional forwarding.
// PARAMETERS
//  DEPTH_LOG2  2  log2 of FIFO entry count (default 4 entries of {address[31:2], wdata})
// PORTS
//  i_clock        in   1   clock; all logic on posedge
//  i_reset        in   1   asynchronous, active-low reset
//  i_rw           in   1   upstream direction: 1 = write, 0 = read
//  i_request      in   1   upstream request, level, held with stable addr/data until o_ready
//  o_ready        out  1   upstream completion, single-cycle pulse
//  i_address      in   32  upstream word address ([1:0] ignored)
//  i_wdata        in   32  upstream write data
//  o_rdata        out  32  upstream read data, valid while o_ready=1
//  i_cacheable    in   1   0 = I/O access: never forwarded
//  o_empty        out  1   1 when FIFO empty and bus FSM in IDLE (fence/flush drain)
//  o_bus_rw       out  1   bus direction
//  o_bus_request  out  1   bus request, level, held until i_bus_ready
//  i_bus_ready    in   1   bus completion pulse
//  o_bus_address  out  32  bus address
//  i_bus_rdata    in   32  bus read data, sampled when i_bus_ready=1
//  o_bus_wdata    out  32  bus write data
// BEHAVIOUR
//  Reset: all outputs 0 except o_empty=1. FIFO rd/wr pointers and count = 0, contents
//   discarded, bus FSM IDLE, o_bus_request drops immediately. A mid-transaction reset
//   abandons the bus cycle; no o_ready is produced for it.
//  Acceptance: new upstream transaction starts on i_request rising edge (registered
//   r_last_request). The request stays high >=1 cycle after o_ready; that tail is ignored.
//  Write: accepted when count < DEPTH (registered count; a same-cycle pop does not free
//   a slot). Push the entry, o_ready pulses the following cycle (1-cycle latency).
//   While full, the write stalls until count drops.
//  Read: ordered after every queued write. When FIFO empty and FSM IDLE, FSM enters
//   READ. o_rdata <= i_bus_rdata and o_ready=1 the cycle after i_bus_ready.
//  Bus FSM: IDLE -> WRITE when count>0 (writes take priority over a pending read);
//   IDLE -> READ when a read is pending and count==0. WRITE: drive head entry,
//   o_bus_rw=1, o_bus_request=1; on i_bus_ready pop the head and return to IDLE.
//   READ: o_bus_rw=0; on i_bus_ready return to IDLE. o_bus_request is 0 in the cycle
//   after i_bus_ready and in IDLE, so there is always one idle cycle between bus cycles.
//   Bus outputs stay stable while requesting.
//  Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.
//  o_empty is registered: 1 when count==0, FSM IDLE and no write is accepted this cycle.
// CONFIGURATION
//  CPU_WRITE_BUFFER_FORWARD_EN defined: a cacheable read whose address[31:2] matches
//   a queued entry completes from the youngest match, with o_ready 1 cycle after acceptance.
//   The bus is not accessed. An entry being popped in the same cycle still counts as a
//   match. Non-matching or non-cacheable reads wait for the drain as above.
//  Undefined: no comparators; every read waits for FIFO empty and goes to the bus.
// TESTING
//  1 Reset with i_reset=0 mid bus write -> o_bus_request=0 at once, o_empty=1,
//    o_ready stays 0.
//  2 Four writes A=0x100..0x10C, D=0x11..0x44, bus ready 5 cycles late -> each o_ready
//    1 cycle after its edge; bus writes issue in order 0x100..0x10C.
//  3 Fifth write while full -> o_ready is held off until the first bus i_bus_ready pop,
//    then pulses; the total bus write count is 5.
//  4 Write 0x200=0xCAFE, then read 0x300 -> the bus write completes before the bus read
//    request; o_rdata = bus value.
//  5 FORWARD_EN: write 0x200=1, write 0x200=2, read 0x200 -> o_rdata=2 after 1 cycle, with
//    no bus read. The same read with i_cacheable=0 goes to the bus after the drain.
//  6 Read with FIFO empty -> bus request next cycle; i_bus_ready with rdata=0x1234 ->
//    o_ready and o_rdata=0x1234 the following cycle.

Source files
------------

// File: rtl/cpu_dcache_write_buffer.sv
`default_nettype none
// =============================================================================
// Module      : cpu_dcache_write_buffer
// Description : Posted-write FIFO between the D-cache bus port and the system
//               bus. Reads stay ordered behind queued writes. Read forwarding
//               from queued writes is enabled by CPU_WRITE_BUFFER_FORWARD_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module cpu_dcache_write_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_rw,
    input  logic        i_request,
    output logic        o_ready,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic        i_cacheable,
    output logic        o_empty,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata
);

    localparam int c_depth = 1 << DEPTH_LOG2;
    localparam int c_cnt_w = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_request;
    logic                  r_wr_pend;
    logic                  r_rd_pend;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [29:0]           r_mem_addr [c_depth];
    logic [31:0]           r_mem_data [c_depth];
    logic                  r_ready;
    logic                  r_empty;
    logic                  r_bus_rw;
    logic                  r_bus_request;
    logic [31:0]           r_rdata;
    logic [31:0]           r_bus_address;
    logic [31:0]           r_bus_wdata;

    logic                  w_edge;
    logic                  w_want_write;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_want_read;
    logic                  w_fwd_hit;
    logic [31:0]           w_fwd_data;

    // Only the rising edge of the level request starts a transaction; the tail is ignored.
    assign w_edge       = i_request & ~r_last_request;
    assign w_want_write = (w_edge & i_rw) | r_wr_pend;
    assign w_push       = w_want_write & (int'(r_count) < c_depth);
    assign w_pop        = (r_state == S_WRITE) & i_bus_ready;
    assign w_want_read  = ((w_edge & ~i_rw) | r_rd_pend) & ~w_fwd_hit;

`ifdef CPU_WRITE_BUFFER_FORWARD_EN
    logic [DEPTH_LOG2-1:0] w_slot;
    logic                  w_fwd_match;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_slot      = r_rd_ptr;
        w_fwd_match = 1'b0;
        w_fwd_data  = '0;
        for (int i = 0; i < c_depth; i++) begin
            w_slot = r_rd_ptr + i[DEPTH_LOG2-1:0];
            if ((i < int'(r_count)) && (r_mem_addr[w_slot] == i_address[31:2])) begin
                w_fwd_match = 1'b1;
                w_fwd_data  = r_mem_data[w_slot];
            end
        end
    end

    assign w_fwd_hit = w_edge & ~i_rw & i_cacheable & w_fwd_match;
`else
    logic w_unused_cacheable;
    assign w_unused_cacheable = i_cacheable;
    assign w_fwd_hit          = 1'b0;
    assign w_fwd_data         = '0;
`endif

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= i_address[31:2];
            r_mem_data[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_last_request <= 1'b0;
            r_wr_pend      <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_ready        <= 1'b0;
            r_empty        <= 1'b1;
            r_rdata        <= '0;
            r_bus_rw       <= 1'b0;
            r_bus_request  <= 1'b0;
            r_bus_address  <= '0;
            r_bus_wdata    <= '0;
        end else begin
            r_last_request <= i_request;
            r_wr_pend      <= w_want_write & ~w_push;
            r_rd_pend      <= w_want_read;
            r_ready        <= w_push | w_fwd_hit | ((r_state == S_READ) & i_bus_ready);
            r_empty        <= (r_count == '0) && (r_state == S_IDLE) && !w_push;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase

            if (w_fwd_hit)
                r_rdata <= w_fwd_data;
            else if ((r_state == S_READ) && i_bus_ready)
                r_rdata <= i_bus_rdata;

            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state       <= S_WRITE;
                        r_bus_rw      <= 1'b1;
                        r_bus_request <= 1'b1;
                        r_bus_address <= {r_mem_addr[r_rd_ptr], 2'b00};
                        r_bus_wdata   <= r_mem_data[r_rd_ptr];
                    end else if (w_want_read) begin
                        r_state       <= S_READ;
                        r_rd_pend     <= 1'b0;
                        r_bus_rw      <= 1'b0;
                        r_bus_request <= 1'b1;
                        r_bus_address <= i_address & 32'hFFFF_FFFC;
                    end
                end
                S_WRITE, S_READ: begin
                    if (i_bus_ready) begin
                        r_state       <= S_IDLE;
                        r_bus_request <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_bus_request <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_rdata       = r_rdata;
    assign o_empty       = r_empty;
    assign o_bus_rw      = r_bus_rw;
    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_bus_address;
    assign o_bus_wdata   = r_bus_wdata;

endmodule
`default_nettype wire
